// File: rtl/frodo_pkg.sv
// Shared definitions for frodo fifo consumers.
//   state_t : consumer FSM encoding (IDLE / RUN / DONE)
//   DEF_DW  : default fifo data width
package frodo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DW = 16;

endpackage

// File: rtl/fifo_rd_tracker.sv
// Tracks reads issued to a fifo and read data returned from it, for a block
// of N words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of both counters (start of a new block)
//   issue      : a read strobe is being issued this cycle
//   accept     : a returned word is being consumed this cycle
//   can_issue  : fewer than N reads issued in this block
//   last_word  : the next accepted word completes the block
//   pending    : at least one read is outstanding (issued != received)
module fifo_rd_tracker #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic issue,
  input  logic accept,
  output logic can_issue,
  output logic last_word,
  output logic pending
);

  // One extra bit so the count can reach N itself.
  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] issued;
  logic [CW-1:0] rcvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued <= '0;
      rcvd   <= '0;
    end else if (clr) begin
      issued <= '0;
      rcvd   <= '0;
    end else begin
      if (issue)  issued <= issued + CW'(1);
      if (accept) rcvd   <= rcvd + CW'(1);
    end
  end

  assign can_issue = (issued < CW'(N));
  assign last_word = (rcvd == CW'(N - 1));
  assign pending   = (issued != rcvd);

endmodule

// File: rtl/fifo_block_acc.sv
// Read-side consumer for the fifo RD/EMPTY/VALID interface. Drains DW-bit
// words from the fifo, sums each block of N words and presents the result
// on a valid/ready port.
// Optional feature: define FIFO_BLOCK_AVG_EN to report the block mean
// (sum >> log2(N), truncating) instead of the raw sum.
// Ports:
//   CLK        : clock, all logic on posedge
//   RST        : asynchronous active-low reset
//   EMPTY      : fifo empty flag
//   VALID      : fifo read data valid, one cycle after an accepted RD
//   DIN        : fifo read data, used only with VALID
//   RD         : fifo read strobe (combinational, never while EMPTY)
//   SUM        : block result, stable while SUM_VALID
//   SUM_VALID  : result valid
//   SUM_READY  : downstream accepts result
//   BUSY       : high in RUN or DONE
//   STATE      : FSM state, for observation
// Handshake: a result transfers on a rising edge where SUM_VALID and
// SUM_READY are both high; SUM/SUM_VALID do not change until then, and
// SUM_READY has no effect while SUM_VALID is low.
module fifo_block_acc
  import frodo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int N  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EMPTY,
  input  logic                      VALID,
  input  logic [DW-1:0]             DIN,
  output logic                      RD,
  output logic [DW+$clog2(N)-1:0]   SUM,
  output logic                      SUM_VALID,
  input  logic                      SUM_READY,
  output logic                      BUSY,
  output state_t                    STATE
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = DW + LOG2N;

  state_t        state, state_d;
  logic [SW-1:0] acc, acc_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] acc_plus;
  logic          clr, issue, accept;
  logic          can_issue, last_word, pending;

  fifo_rd_tracker #(.N(N)) u_tracker (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (clr),
    .issue     (issue),
    .accept    (accept),
    .can_issue (can_issue),
    .last_word (last_word),
    .pending   (pending)
  );

  assign acc_plus = acc + SW'(DIN);

  always_comb begin
    state_d = state;
    acc_d   = acc;
    sum_d   = sum_q;
    clr     = 1'b0;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_d = ST_RUN;
        clr     = 1'b1;
        acc_d   = '0;
      end
      ST_RUN: begin
        issue  = ~EMPTY & can_issue;
        // VALID without an outstanding read is a stray and is dropped.
        accept = VALID & pending;
        if (accept) begin
          acc_d = acc_plus;
          if (last_word) begin
            state_d = ST_DONE;
`ifdef FIFO_BLOCK_AVG_EN
            sum_d = acc_plus >> LOG2N;
`else
            sum_d = acc_plus;
`endif
          end
        end
      end
      ST_DONE: begin
        if (SUM_READY) begin
          state_d = ST_RUN;
          clr     = 1'b1;
          acc_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      acc   <= '0;
      sum_q <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign RD        = issue;
  assign SUM       = sum_q;
  assign SUM_VALID = (state == ST_DONE);
  assign BUSY      = (state == ST_RUN) || (state == ST_DONE);
  assign STATE     = state;

endmodule

// File: tb/tb_fifo_block_acc.sv
module tb_fifo_block_acc;
  import frodo_pkg::*;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = DW + $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          empty;
  logic          valid;
  logic [DW-1:0] din;
  logic          rd;
  logic [SW-1:0] sum;
  logic          sum_valid;
  logic          sum_ready;
  logic          busy;
  state_t        state;

  // fifo model
  logic [DW-1:0] mem[$];
  logic [DW-1:0] wr_q[$];
  logic          fvalid;
  logic [DW-1:0] fdout;
  logic          rd_s;
  logic          inj_valid;
  logic [DW-1:0] inj_data;

  // scoreboard
  logic [SW-1:0] exp_q[$];
  int            total;
  int            bad;
  int            vcount;
  int            blk_rcv;
  logic          expect_sv;
  logic          prev_sv;
  logic          prev_hs;
  logic [SW-1:0] prev_sum;

  assign valid = fvalid | inj_valid;
  assign din   = inj_valid ? inj_data : fdout;

  fifo_block_acc #(.DW(DW), .N(N)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .EMPTY     (empty),
    .VALID     (valid),
    .DIN       (din),
    .RD        (rd),
    .SUM       (sum),
    .SUM_VALID (sum_valid),
    .SUM_READY (sum_ready),
    .BUSY      (busy),
    .STATE     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RD is stable from just after a posedge to the next one; capture it
  // mid-cycle so the fifo model does not race the DUT at the edge.
  always @(negedge clk) rd_s = rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.delete();
      wr_q.delete();
      fvalid <= 1'b0;
      fdout  <= '0;
      empty  <= 1'b1;
    end else begin
      if (rd_s && mem.size() > 0) begin
        fdout  <= mem.pop_front();
        fvalid <= 1'b1;
      end else begin
        fvalid <= 1'b0;
      end
      while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
      empty <= (mem.size() == 0);
    end
  end

  function automatic logic [SW-1:0] fe(input logic [SW-1:0] s);
`ifdef FIFO_BLOCK_AVG_EN
    return s >> $clog2(N);
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] v);
    wr_q.push_back(v);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_sum(input string tag);
    int n;
    n = 0;
    while (!sum_valid && n < 100) begin
      tick();
      n++;
    end
    check(tag, sum_valid, 1);
  endtask

  // monitor: latency, protocol and scoreboard compare
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      blk_rcv   = 0;
      expect_sv = 1'b0;
      prev_sv   = 1'b0;
      prev_hs   = 1'b0;
    end else begin
      if (expect_sv) begin
        check("sv_latency", sum_valid, 1);
        expect_sv = 1'b0;
      end
      if (fvalid) begin
        vcount++;
        blk_rcv++;
        if (blk_rcv == N) begin
          expect_sv = 1'b1;
          blk_rcv   = 0;
        end
      end
      check("rd_vs_empty", rd & empty, 0);
      if (sum_valid) check("rd_in_done", rd, 0);
      if (prev_sv && !prev_hs && sum_valid) check("sum_stable", sum, prev_sum);
      if (sum_valid && sum_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sum_unexpected got=%0h exp=none", sum);
        end else begin
          check("sum", sum, exp_q.pop_front());
        end
      end
      prev_sv  = sum_valid;
      prev_hs  = sum_valid && sum_ready;
      prev_sum = sum;
    end
  end

  initial begin
    int v0;
    int n;
    total     = 0;
    bad       = 0;
    vcount    = 0;
    rst_n     = 1'b0;
    sum_ready = 1'b1;
    inj_valid = 1'b0;
    inj_data  = '0;

    repeat (3) tick();
    check("rst_rd", rd, 0);
    check("rst_sum", sum, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("run_busy", busy, 1);
    check("run_state", state, ST_RUN);

    // 1: 1,2,3,4 read on four consecutive cycles
    push(1); push(2); push(3); push(4);
    exp_q.push_back(fe(10));
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_on", rd, 1);
      tick();
    end
    check("t1_rd_off", rd, 0);
    drain("t1_drain");

    // 2: full-scale words
    for (int i = 0; i < 4; i++) push(16'hFFFF);
    exp_q.push_back(fe(18'h3FFFC));
    drain("t2_drain");

    // 3: back-pressure with the next block already queued
    sum_ready = 1'b0;
    push(3); push(3); push(3); push(3);
    push(10); push(20); push(30); push(40);
    exp_q.push_back(fe(12));
    exp_q.push_back(fe(100));
    wait_sum("t3_wait");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_rd", rd, 0);
      check("t3_hold_sv", sum_valid, 1);
      check("t3_hold_sum", sum, fe(12));
      tick();
    end
    sum_ready = 1'b1;
    tick();
    check("t3_restart_rd", rd, 1);
    check("t3_restart_sv", sum_valid, 0);
    drain("t3_drain");

    // 4: fifo runs dry mid-block
    push(5); push(6);
    exp_q.push_back(fe(26));
    repeat (12) tick();
    check("t4_pause_rd", rd, 0);
    check("t4_pause_sv", sum_valid, 0);
    push(7); push(8);
    drain("t4_drain");

    // 5: async reset after two words of a block
    push(9); push(9); push(9); push(9);
    v0 = vcount;
    n = 0;
    while (vcount < v0 + 2 && n < 100) begin
      tick();
      #2;
      n++;
    end
    check("t5_two_valids", (vcount >= v0 + 2), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rd", rd, 0);
    check("t5_rst_sum", sum, 0);
    check("t5_rst_sv", sum_valid, 0);
    check("t5_rst_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    push(1); push(1); push(1); push(1);
    exp_q.push_back(fe(4));
    drain("t5_drain");

    // 6: stray VALID with nothing outstanding
    inj_data  = 16'd100;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("t6_no_sv", sum_valid, 0);
    push(1); push(2); push(3); push(4);
    exp_q.push_back(fe(10));
    drain("t6_drain");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
